// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 sets of 32-byte lines held in flops,
// single-cycle hits, and a WRITEBACK/FILL sequence towards the line-burst memory port on a miss.

module l1_dcache_checker (
  input logic        clk,
  input logic        rst,
  input logic        mem_read,
  input logic        mem_write,
  input logic        pmem_read,
  input logic        pmem_write,
  input logic        pmem_resp,
  input logic [31:0] pmem_address
);
  a_cpu_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
  a_pmem_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(pmem_read && pmem_write));
  a_pmem_addr_stable: assert property (@(posedge clk) disable iff (rst)
    ((pmem_read || pmem_write) && $past(pmem_read || pmem_write) && !$past(pmem_resp))
      |-> $stable(pmem_address));
endmodule

module l1_dcache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  state_e state_r, next_state_s;

  logic [SETS-1:0]  valid_r;
  logic [SETS-1:0]  dirty_r;
  logic [TAG_W-1:0] tag_r  [SETS];
  logic [255:0]     line_r [SETS];
  // Line address of the outstanding miss, so the pmem side stays stable even if the CPU drops its request.
  logic [26:0]      miss_line_r;

  logic [TAG_W-1:0]   req_tag_s;
  logic [S_INDEX-1:0] req_set_s;
  logic [2:0]         req_word_s;
  logic [TAG_W-1:0]   miss_tag_s;
  logic [S_INDEX-1:0] miss_set_s;
  logic               req_s;
  logic               hit_s;
  logic [31:0]        hit_word_s;
  logic               store_hit_s;
  logic               wb_done_s;
  logic               fill_done_s;
  logic               miss_start_s;
  logic               unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

  assign req_tag_s  = mem_address[31:5+S_INDEX];
  assign req_set_s  = mem_address[4+S_INDEX:5];
  assign req_word_s = mem_address[4:2];
  assign miss_tag_s = miss_line_r[26:S_INDEX];
  assign miss_set_s = miss_line_r[S_INDEX-1:0];
  assign req_s      = mem_read | mem_write;
  assign hit_s      = valid_r[req_set_s] && (tag_r[req_set_s] == req_tag_s);
  assign hit_word_s = line_r[req_set_s][{req_word_s, 5'd0} +: 32];
  assign unused_s   = ^mem_address[1:0];

  // Next-state decode and all port outputs; a simultaneous read and write is handled as a write.
  always_comb begin
    next_state_s = state_r;
    mem_resp     = 1'b0;
    mem_rdata    = 32'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = {256{1'b0}};
    store_hit_s  = 1'b0;
    wb_done_s    = 1'b0;
    fill_done_s  = 1'b0;
    miss_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            store_hit_s = 1'b1;
          end else begin
            mem_rdata = hit_word_s;
          end
        end else if (req_s) begin
          miss_start_s = 1'b1;
          if (valid_r[req_set_s] && dirty_r[req_set_s]) begin
            next_state_s = WRITEBACK;
          end else begin
            next_state_s = FILL;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_r[miss_set_s], miss_set_s, 5'd0};
        pmem_wdata   = line_r[miss_set_s];
        if (pmem_resp) begin
          wb_done_s    = 1'b1;
          next_state_s = FILL;
        end else begin
          next_state_s = WRITEBACK;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line_r, 5'd0};
        if (pmem_resp) begin
          fill_done_s  = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = FILL;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Valid/dirty bookkeeping and capture of the missing line address.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= {SETS{1'b0}};
      dirty_r     <= {SETS{1'b0}};
      miss_line_r <= 27'd0;
    end else begin
      if (miss_start_s) begin
        miss_line_r <= mem_address[31:5];
      end
      if (fill_done_s) begin
        valid_r[miss_set_s] <= 1'b1;
        dirty_r[miss_set_s] <= 1'b0;
      end else if (wb_done_s) begin
        dirty_r[miss_set_s] <= 1'b0;
      end else if (store_hit_s) begin
        dirty_r[req_set_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; not reset because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_done_s && !rst) begin
      line_r[miss_set_s] <= pmem_rdata;
      tag_r[miss_set_s]  <= miss_tag_s;
    end else if (store_hit_s && !rst) begin
      line_r[req_set_s][{req_word_s, 5'd0} +: 32] <= merge_bytes(hit_word_s, mem_wdata, mem_byte_enable);
    end
  end

  l1_dcache_checker u_checker (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .pmem_address (pmem_address)
  );
endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: a line-burst memory responder with configurable latency,
// hand-computed vectors for the named scenarios, then random accesses against a golden word model.

module tb_l1_dcache;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int errors = 0;
  int checks = 0;
  int resp_delay = 1;
  bit rand_delay = 1'b0;
  int rd_cnt = 0;
  int wb_cnt = 0;
  logic [31:0]  last_fill_addr = 32'd0;
  logic [31:0]  last_wb_addr = 32'd0;
  logic [255:0] last_wb_data = {256{1'b0}};
  logic [255:0] mem_lines [logic [26:0]];
  logic [31:0]  gold [logic [29:0]];

  l1_dcache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  // Initial backing-store contents: a hash of the word address, with one planted word.
  function automatic logic [31:0] backing_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (wa * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 8; w++) begin
      l[32*w +: 32] = backing_word({la, 5'd0} + 32'(w * 4));
    end
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    if (gold.exists(a[31:2])) return gold[a[31:2]];
    return backing_word(a);
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers each pmem request after cur_delay cycles of it being held.
  initial begin
    int cnt;
    int cur_delay;
    cnt = 0;
    cur_delay = 1;
    pmem_resp = 1'b0;
    pmem_rdata = {256{1'b0}};
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (cnt == 0) cur_delay = rand_delay ? int'($urandom_range(1, 20)) : resp_delay;
        cnt++;
        if (cnt >= cur_delay) begin
          pmem_resp = 1'b1;
          cnt = 0;
          chk("pmem_align", {27'd0, pmem_address[4:0]}, 32'd0);
          if (pmem_write) begin
            mem_lines[pmem_address[31:5]] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            wb_cnt++;
          end else begin
            pmem_rdata = mem_line(pmem_address[31:5]);
            last_fill_addr = pmem_address;
            rd_cnt++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int n, output logic [31:0] rd);
    @(negedge clk);
    mem_read = ~wr;
    mem_write = wr;
    mem_address = addr;
    mem_byte_enable = be;
    mem_wdata = wd;
    n = 0;
    #1;
    while (!mem_resp && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("access_timeout", 32'(n), 32'd0);
    rd = mem_rdata;
    if (wr && mem_resp) gold[addr[31:2]] = apply_be(gold_word(addr), wd, be);
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    logic wr;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'd0;
    mem_byte_enable = 4'd0;
    mem_wdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    // Cold read miss, fill latency 3
    resp_delay = 3;
    access(1'b0, 32'h0000_1004, 4'h0, 32'd0, n, rd);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_fill_addr", last_fill_addr, 32'h0000_1000);
    chk("t1_wb_cnt", 32'(wb_cnt), 32'd0);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd1);

    // Partial store hit then reread
    access(1'b1, 32'h0000_1004, 4'b0011, 32'h1234_5678, n, rd);
    chk("t2_store_latency", 32'(n), 32'd0);
    access(1'b0, 32'h0000_1004, 4'h0, 32'd0, n, rd);
    chk("t2_reread", rd, 32'hDEAD_5678);
    chk("t2_reread_latency", 32'(n), 32'd0);

    // Conflict miss on a dirty victim: writeback then fill
    resp_delay = 2;
    access(1'b0, 32'h0000_2004, 4'h0, 32'd0, n, rd);
    chk("t3_rdata", rd, backing_word(32'h0000_2004));
    chk("t3_latency", 32'(n), 32'd5);
    chk("t3_wb_addr", last_wb_addr, 32'h0000_1000);
    chk("t3_wb_word1", last_wb_data[63:32], 32'hDEAD_5678);
    chk("t3_wb_word0", last_wb_data[31:0], backing_word(32'h0000_1000));
    chk("t3_fill_addr", last_fill_addr, 32'h0000_2000);
    chk("t3_wb_cnt", 32'(wb_cnt), 32'd1);

    // Back-to-back hits across one line
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 32'h0000_2000 + 32'(4 * i), 4'h0, 32'd0, n, rd);
      chk("t4_hit_latency", 32'(n), 32'd0);
      chk("t4_hit_rdata", rd, backing_word(32'h0000_2000 + 32'(4 * i)));
    end
    chk("t4_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("t4_wb_cnt", 32'(wb_cnt), 32'd1);

    // Store with no byte lanes: hit, data unchanged, line becomes dirty
    access(1'b1, 32'h0000_2008, 4'b0000, 32'hFFFF_FFFF, n, rd);
    chk("be0_latency", 32'(n), 32'd0);
    access(1'b0, 32'h0000_2008, 4'h0, 32'd0, n, rd);
    chk("be0_reread", rd, backing_word(32'h0000_2008));
    resp_delay = 1;
    access(1'b0, 32'h0000_1004, 4'h0, 32'd0, n, rd);
    chk("be0_evict_latency", 32'(n), 32'd3);
    chk("be0_evict_wb_cnt", 32'(wb_cnt), 32'd2);
    chk("be0_evict_wb_addr", last_wb_addr, 32'h0000_2000);
    chk("refetch_rdata", rd, 32'hDEAD_5678);

    // Reset two cycles into a fill
    resp_delay = 10;
    @(negedge clk);
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_address = 32'h0000_3028;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_in_fill", {31'd0, pmem_read}, 32'd1);
    rst = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_pmem_read_dropped", {31'd0, pmem_read}, 32'd0);
    chk("t5_pmem_write_low", {31'd0, pmem_write}, 32'd0);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd3);
    rst = 1'b0;
    resp_delay = 2;
    access(1'b0, 32'h0000_3028, 4'h0, 32'd0, n, rd);
    chk("t5_same_addr_misses", 32'(n), 32'd3);
    chk("t5_same_addr_rdata", rd, backing_word(32'h0000_3028));
    access(1'b0, 32'h0000_1004, 4'h0, 32'd0, n, rd);
    chk("t5_old_line_invalid", 32'(n), 32'd3);
    chk("t5_old_line_rdata", rd, 32'hDEAD_5678);

    // Random accesses with random memory latency against the golden model
    rand_delay = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      access(wr, addr, be, wd, n, rd);
      if (!wr) chk("rand_rdata", rd, gold_word(addr));
    end

    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
